// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and default widths for the instruction prefetch front end.
// The FSM states and the FIFO entry layout are both defined here.
package fetch_prefetch_unit_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_INST_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// First-word-fall-through FIFO holding fetched {pc, inst} entries.
// Clear wins over push/pop; the head entry is always visible on head_o.
module fetch_prefetch_unit_fifo
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  entry_t                 push_data_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_C) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !clear_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: streams sequential reads from a synchronous
// instruction memory into a prefetch FIFO and flushes/refetches on redirect.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INST_W   = DEF_INST_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   imem_en_o,
  output logic [ADDR_W-1:0]      imem_addr_o,
  input  logic [INST_W-1:0]      imem_rdata_i,
  input  logic                   redirect_valid_i,
  input  logic [ADDR_W-1:0]      redirect_pc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [INST_W-1:0]      out_inst_o,
  output logic [ADDR_W-1:0]      out_pc_o,
  output logic [$clog2(DEPTH):0] fifo_count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
  logic              inflight_q;

  logic              active, redirect, credit_ok, issue, push, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  entry_t            push_data, head;

  // Credits count both buffered words and the one read still in flight, so
  // the FIFO can never be asked to accept more than it holds.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok = occupancy < DEPTH_C;

  assign active   = (state_q == RUN) || (state_q == FLUSH);
  assign redirect = redirect_valid_i && (state_q != IDLE);
  assign issue    = active && credit_ok && !redirect;
  assign push     = inflight_q && (state_q == RUN) && !redirect;
  assign pop      = out_valid_o && out_ready_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      state_d    = FLUSH;
      fetch_pc_d = redirect_pc_i;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
      issue_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= issue;
    end
  end

  assign push_data = '{pc: issue_pc_q, inst: imem_rdata_i};

  fetch_prefetch_unit_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (redirect),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign imem_en_o    = issue;
  assign imem_addr_o  = fetch_pc_q;
  assign out_valid_o  = (fifo_count != '0);
  assign out_inst_o   = head.inst;
  assign out_pc_o     = head.pc;
  assign fifo_count_o = fifo_count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: a cycle table for start-up and
// backpressure, hand sequences for redirect/reset corners, then random traffic.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        outReady = 1'b0;
  logic        redirectValid = 1'b0;
  logic [15:0] redirectPc = 16'h0;

  logic        imemEn, outValid;
  logic [15:0] imemAddr, outPc;
  logic [31:0] imemRdata, outInst;
  logic [2:0]  fifoCount;

  logic        wrapImemEn, wrapOutValid;
  logic [15:0] wrapImemAddr, wrapOutPc;
  logic [31:0] wrapImemRdata, wrapOutInst;
  logic [2:0]  wrapFifoCount;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_en_o(imemEn), .imem_addr_o(imemAddr), .imem_rdata_i(imemRdata),
    .redirect_valid_i(redirectValid), .redirect_pc_i(redirectPc),
    .out_valid_o(outValid), .out_ready_i(outReady),
    .out_inst_o(outInst), .out_pc_o(outPc), .fifo_count_o(fifoCount)
  );

  fetch_prefetch_unit #(.RESET_PC(16'hFFFE)) dutWrap (
    .clk_i(clk), .rst_i(rst),
    .imem_en_o(wrapImemEn), .imem_addr_o(wrapImemAddr), .imem_rdata_i(wrapImemRdata),
    .redirect_valid_i(1'b0), .redirect_pc_i(16'h0),
    .out_valid_o(wrapOutValid), .out_ready_i(outReady),
    .out_inst_o(wrapOutInst), .out_pc_o(wrapOutPc), .fifo_count_o(wrapFifoCount)
  );

  function automatic logic [31:0] memWord(input logic [15:0] addr);
    return {16'h0, addr} + 32'h100;
  endfunction

  // Synchronous instruction memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (imemEn) imemRdata <= memWord(imemAddr);
    if (wrapImemEn) wrapImemRdata <= memWord(wrapImemAddr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic readyV, input logic redirV, input logic [15:0] pcV);
    @(posedge clk);
    #1;
    rst = rstV;
    outReady = readyV;
    redirectValid = redirV;
    redirectPc = pcV;
    @(negedge clk);
  endtask

  // Reference model: the next delivered PC restarts at the reset PC or a redirect
  // target and otherwise advances by one per accepted instruction.
  logic [15:0] expNext = 16'h0;
  logic [15:0] wrapNext = 16'hFFFE;
  logic        started = 1'b0;
  int          stall = 0;

  always @(negedge clk) begin
    if (rst) begin
      expNext = 16'h0000;
      wrapNext = 16'hFFFE;
      started = 1'b0;
      stall = 0;
    end else begin
      checkOutput("sbValidVsCount", 32'(outValid), 32'(fifoCount != 3'd0));
      checkOutput("sbCountBound", 32'(fifoCount > 3'd4), 32'd0);
      if (outValid && outReady) begin
        checkOutput("sbPc", 32'(outPc), 32'(expNext));
        checkOutput("sbInst", outInst, memWord(expNext));
      end
      if (wrapOutValid && outReady) begin
        checkOutput("sbWrapPc", 32'(wrapOutPc), 32'(wrapNext));
        checkOutput("sbWrapInst", wrapOutInst, memWord(wrapNext));
        wrapNext = wrapNext + 16'h1;
      end
      if (outReady && !outValid) stall++;
      else stall = 0;
      checkOutput("sbStallBound", 32'(stall > 3), 32'd0);
      if (redirectValid && started) begin
        expNext = redirectPc;
        stall = 0;
      end else if (outValid && outReady) begin
        expNext = expNext + 16'h1;
      end
      started = 1'b1;
    end
  end

  typedef struct {
    logic        ready;
    logic        expEn;
    logic [15:0] expAddr;
    logic        expValid;
    logic [15:0] expPc;
    logic [2:0]  expCount;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [15:0] wrapExp;

    // Cycle 0 is the first cycle with reset released; ready drops at cycles 7-10.
    vecs[0]  = '{1'b1, 1'b0, 16'd0,  1'b0, 16'd0, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 16'd0,  1'b0, 16'd0, 3'd0};
    vecs[2]  = '{1'b1, 1'b1, 16'd1,  1'b0, 16'd0, 3'd0};
    vecs[3]  = '{1'b1, 1'b1, 16'd2,  1'b1, 16'd0, 3'd1};
    vecs[4]  = '{1'b1, 1'b1, 16'd3,  1'b1, 16'd1, 3'd1};
    vecs[5]  = '{1'b1, 1'b1, 16'd4,  1'b1, 16'd2, 3'd1};
    vecs[6]  = '{1'b1, 1'b1, 16'd5,  1'b1, 16'd3, 3'd1};
    vecs[7]  = '{1'b0, 1'b1, 16'd6,  1'b1, 16'd4, 3'd1};
    vecs[8]  = '{1'b0, 1'b1, 16'd7,  1'b1, 16'd4, 3'd2};
    vecs[9]  = '{1'b0, 1'b0, 16'd0,  1'b1, 16'd4, 3'd3};
    vecs[10] = '{1'b0, 1'b0, 16'd0,  1'b1, 16'd4, 3'd4};
    vecs[11] = '{1'b1, 1'b0, 16'd0,  1'b1, 16'd4, 3'd4};
    vecs[12] = '{1'b1, 1'b1, 16'd8,  1'b1, 16'd5, 3'd3};
    vecs[13] = '{1'b1, 1'b1, 16'd9,  1'b1, 16'd6, 3'd2};
    vecs[14] = '{1'b1, 1'b1, 16'd10, 1'b1, 16'd7, 3'd2};
    vecs[15] = '{1'b1, 1'b1, 16'd11, 1'b1, 16'd8, 3'd2};

    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    checkOutput("resetValid", 32'(outValid), 32'd0);
    checkOutput("resetEn", 32'(imemEn), 32'd0);
    checkOutput("resetCount", 32'(fifoCount), 32'd0);
    checkOutput("resetPc", 32'(outPc), 32'd0);
    checkOutput("resetInst", outInst, 32'd0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, vecs[i].ready, 1'b0, 16'h0);
      checkOutput($sformatf("row%0d.en", i), 32'(imemEn), 32'(vecs[i].expEn));
      checkOutput($sformatf("row%0d.valid", i), 32'(outValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("row%0d.count", i), 32'(fifoCount), 32'(vecs[i].expCount));
      checkOutput($sformatf("row%0d.wrapEn", i), 32'(wrapImemEn), 32'(vecs[i].expEn));
      checkOutput($sformatf("row%0d.wrapCount", i), 32'(wrapFifoCount), 32'(vecs[i].expCount));
      if (vecs[i].expEn) begin
        checkOutput($sformatf("row%0d.addr", i), 32'(imemAddr), 32'(vecs[i].expAddr));
        wrapExp = vecs[i].expAddr + 16'hFFFE;
        checkOutput($sformatf("row%0d.wrapAddr", i), 32'(wrapImemAddr), 32'(wrapExp));
      end
      if (vecs[i].expValid) begin
        checkOutput($sformatf("row%0d.pc", i), 32'(outPc), 32'(vecs[i].expPc));
        checkOutput($sformatf("row%0d.inst", i), outInst, memWord(vecs[i].expPc));
        wrapExp = vecs[i].expPc + 16'hFFFE;
        checkOutput($sformatf("row%0d.wrapPc", i), 32'(wrapOutPc), 32'(wrapExp));
      end
    end

    // Single redirect mid-stream.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040);
    checkOutput("redirEnForcedLow", 32'(imemEn), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("redirFlushValid", 32'(outValid), 32'd0);
    checkOutput("redirFlushEn", 32'(imemEn), 32'd1);
    checkOutput("redirFlushAddr", 32'(imemAddr), 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("redirC2Valid", 32'(outValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("redirC3Valid", 32'(outValid), 32'd1);
    checkOutput("redirC3Pc", 32'(outPc), 32'h40);
    checkOutput("redirC3Inst", outInst, 32'h140);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("redirC4Pc", 32'(outPc), 32'h41);

    // Back-to-back redirects: the first target must never be delivered.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020);
    checkOutput("b2bEnForcedLow", 32'(imemEn), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("b2bFlushAddr", 32'(imemAddr), 32'h20);
    checkOutput("b2bFlushValid", 32'(outValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("b2bC2Valid", 32'(outValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("b2bC3Valid", 32'(outValid), 32'd1);
    checkOutput("b2bC3Pc", 32'(outPc), 32'h20);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("b2bC4Pc", 32'(outPc), 32'h21);

    // Fill the FIFO, then reset together with a redirect.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("fullCount", 32'(fifoCount), 32'd4);
    checkOutput("fullEn", 32'(imemEn), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0077);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("rstRedirValid", 32'(outValid), 32'd0);
    checkOutput("rstRedirEn", 32'(imemEn), 32'd0);
    checkOutput("rstRedirCount", 32'(fifoCount), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("rstRestartEn", 32'(imemEn), 32'd1);
    checkOutput("rstRestartAddr", 32'(imemAddr), 32'h0);

    // Random traffic, with redirect targets biased toward the top of the address space.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] pc;
      pc = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (16'hFFFC + 16'($urandom_range(0, 3)));
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), pc);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
